// File: rtl/mem_rd_arbiter_pkg.sv
// Shared widths and defaults for the DDR read arbiter slice.
// Request FSM encodings live here so the status word and bench agree on them.
package mem_rd_arbiter_pkg;

  localparam int AXI4S_DATA_WIDTH = 64;
  localparam int AXI4L_DATA_WIDTH = 32;

  localparam int MEM_RD_MAX_REQ   = 4;
  localparam int MEM_RD_ORD_DEPTH = 8;

  localparam logic REQ_IDLE = 1'b0;
  localparam logic REQ_FWD  = 1'b1;

endpackage

// File: rtl/mem_rd_order_fifo.sv
// Synchronous FIFO that remembers which requester owns each outstanding read, in grant order.
// Storage is not reset; flushing the pointers and the count is enough to empty it.
module mem_rd_order_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing one DDR read engine; routes response packets back by grant order.
//   state    | meaning
//   REQ_IDLE | searching for a requester from rr_ptr, grant when order FIFO has room
//   REQ_FWD  | holding the latched request word on m_req until the reader accepts it
module mem_rd_arbiter
  import mem_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = MEM_RD_MAX_REQ,
  parameter int REQ_IDX_WIDTH = 2,
  parameter int ORD_DEPTH     = MEM_RD_ORD_DEPTH
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_REQ*AXI4S_DATA_WIDTH-1:0] s_req_tdata,
  input  logic [NUM_REQ-1:0]                s_req_tvalid,
  output logic [NUM_REQ-1:0]                s_req_tready,
  output logic [AXI4S_DATA_WIDTH-1:0]       m_req_tdata,
  output logic                              m_req_tvalid,
  input  logic                              m_req_tready,
  input  logic [AXI4S_DATA_WIDTH-1:0]       s_rsp_tdata,
  input  logic                              s_rsp_tlast,
  input  logic                              s_rsp_tuser,
  input  logic                              s_rsp_tvalid,
  output logic                              s_rsp_tready,
  output logic [AXI4S_DATA_WIDTH-1:0]       m_rsp_tdata,
  output logic                              m_rsp_tlast,
  output logic                              m_rsp_tuser,
  output logic [NUM_REQ-1:0]                m_rsp_tvalid,
  input  logic [NUM_REQ-1:0]                m_rsp_tready,
  output logic [AXI4L_DATA_WIDTH-1:0]       status_out
);

  localparam int DW = AXI4S_DATA_WIDTH;
  localparam int CW = $clog2(ORD_DEPTH) + 1;

  logic                     req_state;
  logic [REQ_IDX_WIDTH-1:0] rr_ptr;
  logic [REQ_IDX_WIDTH-1:0] grant;
  logic [REQ_IDX_WIDTH-1:0] search_idx;
  logic                     grant_valid;
  logic                     accept;
  logic [DW-1:0]            grant_data;
  logic                     ord_full;
  logic                     ord_empty;
  logic [CW-1:0]            ord_count;
  logic [REQ_IDX_WIDTH-1:0] head;
  logic                     rsp_pop;
  logic                     overflow;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    search_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      search_idx = REQ_IDX_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
      if (!grant_valid && s_req_tvalid[search_idx]) begin
        grant_valid = 1'b1;
        grant       = search_idx;
      end
    end
  end

  // Gating with reset_n keeps the handshakes quiet while the block is held in reset.
  assign accept       = reset_n & (req_state == REQ_IDLE) & grant_valid & ~ord_full;
  assign s_req_tready = accept ? (NUM_REQ'(1) << grant) : '0;
  assign grant_data   = s_req_tdata[int'(grant)*DW +: DW];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_state    <= REQ_IDLE;
      rr_ptr       <= '0;
      m_req_tdata  <= '0;
      m_req_tvalid <= 1'b0;
    end else begin
      case (req_state)
        REQ_IDLE: if (accept) begin
          m_req_tdata  <= grant_data;
          m_req_tvalid <= 1'b1;
          rr_ptr       <= (grant == REQ_IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
          req_state    <= REQ_FWD;
        end
        REQ_FWD: if (m_req_tready) begin
          m_req_tvalid <= 1'b0;
          req_state    <= REQ_IDLE;
        end
        default: req_state <= REQ_IDLE;
      endcase
    end
  end

  mem_rd_order_fifo #(
    .WIDTH (REQ_IDX_WIDTH),
    .DEPTH (ORD_DEPTH)
  ) u_order_fifo (
    .clk     (clk),
    .srst_n  (reset_n),
    .push    (accept),
    .wr_data (grant),
    .pop     (rsp_pop),
    .rd_data (head),
    .full    (ord_full),
    .empty   (ord_empty),
    .count   (ord_count)
  );

  assign s_rsp_tready = reset_n & ~ord_empty & m_rsp_tready[head];
  assign rsp_pop      = s_rsp_tvalid & s_rsp_tlast & ~ord_empty;

  // The reader never stalls mid-packet, so beats are forwarded regardless of ready.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_rsp_tdata  <= '0;
      m_rsp_tlast  <= 1'b0;
      m_rsp_tuser  <= 1'b0;
      m_rsp_tvalid <= '0;
      overflow     <= 1'b0;
    end else begin
      m_rsp_tdata  <= s_rsp_tdata;
      m_rsp_tlast  <= s_rsp_tlast;
      m_rsp_tuser  <= s_rsp_tuser;
      m_rsp_tvalid <= (s_rsp_tvalid && !ord_empty) ? (NUM_REQ'(1) << head) : '0;
      if (s_rsp_tvalid && (ord_empty || !m_rsp_tready[head])) overflow <= 1'b1;
    end
  end

  always_comb begin
    status_out                        = '0;
    status_out[3:0]                   = 4'(ord_count);
    status_out[4]                     = req_state;
    status_out[5]                     = overflow;
    status_out[8 +: REQ_IDX_WIDTH]    = ord_empty ? '0 : head;
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: grant order, request hold, order-FIFO limits, response routing.
module tb_mem_rd_arbiter;

  localparam int DW = 64;
  localparam int NR = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NR*DW-1:0] s_req_tdata;
  logic [NR-1:0]    s_req_tvalid;
  logic [NR-1:0]    s_req_tready;
  logic [DW-1:0]    m_req_tdata;
  logic             m_req_tvalid;
  logic             m_req_tready;
  logic [DW-1:0]    s_rsp_tdata;
  logic             s_rsp_tlast;
  logic             s_rsp_tuser;
  logic             s_rsp_tvalid;
  logic             s_rsp_tready;
  logic [DW-1:0]    m_rsp_tdata;
  logic             m_rsp_tlast;
  logic             m_rsp_tuser;
  logic [NR-1:0]    m_rsp_tvalid;
  logic [NR-1:0]    m_rsp_tready;
  logic [31:0]      status_out;

  int checks = 0;
  int errors = 0;

  mem_rd_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_req_tdata  (s_req_tdata),
    .s_req_tvalid (s_req_tvalid),
    .s_req_tready (s_req_tready),
    .m_req_tdata  (m_req_tdata),
    .m_req_tvalid (m_req_tvalid),
    .m_req_tready (m_req_tready),
    .s_rsp_tdata  (s_rsp_tdata),
    .s_rsp_tlast  (s_rsp_tlast),
    .s_rsp_tuser  (s_rsp_tuser),
    .s_rsp_tvalid (s_rsp_tvalid),
    .s_rsp_tready (s_rsp_tready),
    .m_rsp_tdata  (m_rsp_tdata),
    .m_rsp_tlast  (m_rsp_tlast),
    .m_rsp_tuser  (m_rsp_tuser),
    .m_rsp_tvalid (m_rsp_tvalid),
    .m_rsp_tready (m_rsp_tready),
    .status_out   (status_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_slices();
    for (int i = 0; i < NR; i++) s_req_tdata[i*DW +: DW] = 64'hA000_0000_0000_0000 | 64'(i);
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    s_req_tdata  = '0;
    s_req_tvalid = '0;
    m_req_tready = 1'b0;
    s_rsp_tdata  = '0;
    s_rsp_tlast  = 1'b0;
    s_rsp_tuser  = 1'b0;
    s_rsp_tvalid = 1'b0;
    m_rsp_tready = '1;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    s_req_tdata  = '1;
    s_req_tvalid = '1;
    m_req_tready = 1'b1;
    s_rsp_tdata  = 64'h1234;
    s_rsp_tlast  = 1'b1;
    s_rsp_tuser  = 1'b1;
    s_rsp_tvalid = 1'b1;
    m_rsp_tready = '1;
    tick();
    tick();
    checks++; if (s_req_tready !== 4'b0000) begin errors++; $display("FAIL reset_s_req_tready: got %b expected 0000", s_req_tready); end
    checks++; if (m_req_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_req_tvalid: got %b expected 0", m_req_tvalid); end
    checks++; if (m_req_tdata !== 64'h0) begin errors++; $display("FAIL reset_m_req_tdata: got %h expected 0", m_req_tdata); end
    checks++; if (s_rsp_tready !== 1'b0) begin errors++; $display("FAIL reset_s_rsp_tready: got %b expected 0", s_rsp_tready); end
    checks++; if (m_rsp_tvalid !== 4'b0000) begin errors++; $display("FAIL reset_m_rsp_tvalid: got %b expected 0000", m_rsp_tvalid); end
    checks++; if ({m_rsp_tdata, m_rsp_tlast, m_rsp_tuser} !== 66'h0) begin errors++; $display("FAIL reset_m_rsp: got %h/%b/%b expected 0", m_rsp_tdata, m_rsp_tlast, m_rsp_tuser); end
    checks++; if (status_out !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected 00000000", status_out); end
  endtask

  task automatic test_single();
    do_reset();
    m_req_tready = 1'b1;
    s_req_tdata[1*DW +: DW] = 64'h0000_0040_0000_0100;
    s_req_tvalid = 4'b0010;
    #1;
    checks++; if (s_req_tready !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b expected 0010", s_req_tready); end
    tick();
    s_req_tvalid = '0;
    #1;
    checks++; if (m_req_tvalid !== 1'b1) begin errors++; $display("FAIL single_m_req_tvalid: got %b expected 1", m_req_tvalid); end
    checks++; if (m_req_tdata !== 64'h0000_0040_0000_0100) begin errors++; $display("FAIL single_m_req_tdata: got %h expected 0000004000000100", m_req_tdata); end
    checks++; if (status_out !== 32'h0000_0111) begin errors++; $display("FAIL single_status_fwd: got %h expected 00000111", status_out); end
    tick();
    checks++; if (m_req_tvalid !== 1'b0) begin errors++; $display("FAIL single_m_req_done: got %b expected 0", m_req_tvalid); end
    checks++; if (status_out !== 32'h0000_0101) begin errors++; $display("FAIL single_status_out1: got %h expected 00000101", status_out); end
    for (int b = 0; b < 3; b++) begin
      s_rsp_tvalid = 1'b1;
      s_rsp_tdata  = 64'hD0 + 64'(b);
      s_rsp_tlast  = (b == 2);
      s_rsp_tuser  = 1'b1;
      #1;
      checks++; if (s_rsp_tready !== 1'b1) begin errors++; $display("FAIL single_s_rsp_tready beat %0d: got %b expected 1", b, s_rsp_tready); end
      tick();
      checks++; if (m_rsp_tvalid !== 4'b0010) begin errors++; $display("FAIL single_m_rsp_tvalid beat %0d: got %b expected 0010", b, m_rsp_tvalid); end
      checks++; if (m_rsp_tdata !== 64'hD0 + 64'(b)) begin errors++; $display("FAIL single_m_rsp_tdata beat %0d: got %h expected %h", b, m_rsp_tdata, 64'hD0 + 64'(b)); end
      checks++; if (m_rsp_tlast !== (b == 2)) begin errors++; $display("FAIL single_m_rsp_tlast beat %0d: got %b expected %b", b, m_rsp_tlast, (b == 2)); end
    end
    s_rsp_tvalid = 1'b0;
    s_rsp_tlast  = 1'b0;
    checks++; if (status_out !== 32'h0) begin errors++; $display("FAIL single_status_end: got %h expected 00000000", status_out); end
    tick();
    checks++; if (m_rsp_tvalid !== 4'b0000) begin errors++; $display("FAIL single_m_rsp_idle: got %b expected 0000", m_rsp_tvalid); end
  endtask

  task automatic test_round_robin();
    int exp_g [5] = '{0, 1, 2, 3, 0};
    do_reset();
    load_slices();
    s_req_tvalid = 4'b1111;
    m_req_tready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      checks++; if (s_req_tready !== 4'(1 << exp_g[g])) begin errors++; $display("FAIL rr_grant %0d: got %b expected %b", g, s_req_tready, 4'(1 << exp_g[g])); end
      tick();
      checks++; if (m_req_tdata !== (64'hA000_0000_0000_0000 | 64'(exp_g[g]))) begin errors++; $display("FAIL rr_m_req_tdata %0d: got %h expected slice %0d", g, m_req_tdata, exp_g[g]); end
      checks++; if (s_req_tready !== 4'b0000) begin errors++; $display("FAIL rr_no_grant_in_fwd %0d: got %b expected 0000", g, s_req_tready); end
      tick();
    end
    s_req_tvalid = '0;
    checks++; if (status_out[3:0] !== 4'd5) begin errors++; $display("FAIL rr_count: got %0d expected 5", status_out[3:0]); end
    for (int k = 0; k < 5; k++) begin
      s_rsp_tvalid = 1'b1;
      s_rsp_tlast  = 1'b1;
      s_rsp_tdata  = 64'(k);
      tick();
      checks++; if (m_rsp_tvalid !== 4'(1 << exp_g[k])) begin errors++; $display("FAIL rr_rsp_route %0d: got %b expected %b", k, m_rsp_tvalid, 4'(1 << exp_g[k])); end
    end
    s_rsp_tvalid = 1'b0;
    s_rsp_tlast  = 1'b0;
    tick();
    checks++; if (m_rsp_tvalid !== 4'b0000) begin errors++; $display("FAIL rr_rsp_idle: got %b expected 0000", m_rsp_tvalid); end
    checks++; if (status_out[3:0] !== 4'd0) begin errors++; $display("FAIL rr_count_end: got %0d expected 0", status_out[3:0]); end
  endtask

  task automatic test_fwd_stall();
    do_reset();
    load_slices();
    s_req_tvalid = 4'b0100;
    m_req_tready = 1'b0;
    #1;
    checks++; if (s_req_tready !== 4'b0100) begin errors++; $display("FAIL stall_grant: got %b expected 0100", s_req_tready); end
    tick();
    s_req_tvalid = 4'b1111;
    s_req_tdata[2*DW +: DW] = 64'hBEEF;
    #1;
    for (int c = 0; c < 20; c++) begin
      checks++; if (m_req_tvalid !== 1'b1 || m_req_tdata !== 64'hA000_0000_0000_0002) begin errors++; $display("FAIL stall_hold cycle %0d: got %b/%h expected 1/a000000000000002", c, m_req_tvalid, m_req_tdata); end
      checks++; if (s_req_tready !== 4'b0000) begin errors++; $display("FAIL stall_no_grant cycle %0d: got %b expected 0000", c, s_req_tready); end
      tick();
    end
    m_req_tready = 1'b1;
    tick();
    s_req_tvalid = '0;
    checks++; if (m_req_tvalid !== 1'b0) begin errors++; $display("FAIL stall_release: got %b expected 0", m_req_tvalid); end
    s_req_tvalid = 4'b1111;
    #1;
    checks++; if (s_req_tready !== 4'b1000) begin errors++; $display("FAIL stall_next_grant: got %b expected 1000", s_req_tready); end
    s_req_tvalid = '0;
  endtask

  task automatic test_fifo_full();
    do_reset();
    load_slices();
    s_req_tvalid = 4'b1111;
    m_req_tready = 1'b1;
    #1;
    for (int g = 0; g < 8; g++) begin
      tick();
      tick();
    end
    checks++; if (status_out[3:0] !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", status_out[3:0]); end
    checks++; if (s_req_tready !== 4'b0000) begin errors++; $display("FAIL full_no_grant: got %b expected 0000", s_req_tready); end
    tick();
    checks++; if (s_req_tready !== 4'b0000 || m_req_tvalid !== 1'b0) begin errors++; $display("FAIL full_hold: got %b/%b expected 0000/0", s_req_tready, m_req_tvalid); end
    s_rsp_tvalid = 1'b1;
    s_rsp_tlast  = 1'b1;
    s_rsp_tdata  = 64'h55;
    #1;
    checks++; if (s_rsp_tready !== 1'b1) begin errors++; $display("FAIL full_rsp_ready: got %b expected 1", s_rsp_tready); end
    checks++; if (s_req_tready !== 4'b0000) begin errors++; $display("FAIL full_before_pop: got %b expected 0000", s_req_tready); end
    tick();
    s_rsp_tdata = 64'h66;
    #1;
    checks++; if (m_rsp_tvalid !== 4'b0001) begin errors++; $display("FAIL full_pop_route: got %b expected 0001", m_rsp_tvalid); end
    checks++; if (s_req_tready !== 4'b0001) begin errors++; $display("FAIL full_grant_after_pop: got %b expected 0001", s_req_tready); end
    tick();
    s_rsp_tvalid = 1'b0;
    s_rsp_tlast  = 1'b0;
    s_req_tvalid = '0;
    checks++; if (m_rsp_tvalid !== 4'b0010) begin errors++; $display("FAIL full_push_pop_route: got %b expected 0010", m_rsp_tvalid); end
    checks++; if (status_out[3:0] !== 4'd7) begin errors++; $display("FAIL full_push_pop_count: got %0d expected 7", status_out[3:0]); end
  endtask

  task automatic test_overflow();
    do_reset();
    checks++; if (status_out[5] !== 1'b0) begin errors++; $display("FAIL ovf_initial: got %b expected 0", status_out[5]); end
    load_slices();
    s_req_tvalid = 4'b0100;
    m_req_tready = 1'b1;
    tick();
    s_req_tvalid = '0;
    tick();
    m_rsp_tready = 4'b0100;
    s_rsp_tvalid = 1'b1;
    s_rsp_tdata  = 64'hA1;
    #1;
    checks++; if (s_rsp_tready !== 1'b1) begin errors++; $display("FAIL ovf_beat0_ready: got %b expected 1", s_rsp_tready); end
    tick();
    checks++; if (m_rsp_tvalid !== 4'b0100 || status_out[5] !== 1'b0) begin errors++; $display("FAIL ovf_beat0: got %b/%b expected 0100/0", m_rsp_tvalid, status_out[5]); end
    m_rsp_tready = 4'b0000;
    s_rsp_tdata  = 64'hB2;
    #1;
    checks++; if (s_rsp_tready !== 1'b0) begin errors++; $display("FAIL ovf_beat1_ready: got %b expected 0", s_rsp_tready); end
    tick();
    checks++; if (m_rsp_tvalid !== 4'b0100 || m_rsp_tdata !== 64'hB2) begin errors++; $display("FAIL ovf_beat1_fwd: got %b/%h expected 0100/b2", m_rsp_tvalid, m_rsp_tdata); end
    checks++; if (status_out[5] !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", status_out[5]); end
    m_rsp_tready = 4'b0100;
    s_rsp_tdata  = 64'hC3;
    s_rsp_tlast  = 1'b1;
    tick();
    checks++; if (m_rsp_tvalid !== 4'b0100 || status_out[3:0] !== 4'd0) begin errors++; $display("FAIL ovf_beat2: got %b/%0d expected 0100/0", m_rsp_tvalid, status_out[3:0]); end
    s_rsp_tvalid = 1'b0;
    s_rsp_tlast  = 1'b0;
    tick();
    checks++; if (status_out !== 32'h0000_0020) begin errors++; $display("FAIL ovf_sticky: got %h expected 00000020", status_out); end
    do_reset();
    checks++; if (status_out !== 32'h0) begin errors++; $display("FAIL ovf_cleared: got %h expected 00000000", status_out); end
    s_rsp_tvalid = 1'b1;
    s_rsp_tlast  = 1'b1;
    s_rsp_tdata  = 64'hDD;
    #1;
    checks++; if (s_rsp_tready !== 1'b0) begin errors++; $display("FAIL empty_rsp_ready: got %b expected 0", s_rsp_tready); end
    tick();
    s_rsp_tvalid = 1'b0;
    s_rsp_tlast  = 1'b0;
    checks++; if (m_rsp_tvalid !== 4'b0000) begin errors++; $display("FAIL empty_drop: got %b expected 0000", m_rsp_tvalid); end
    checks++; if (status_out !== 32'h0000_0020) begin errors++; $display("FAIL empty_ovf: got %h expected 00000020", status_out); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    load_slices();
    s_req_tvalid = 4'b1111;
    m_req_tready = 1'b1;
    #1;
    tick(); tick();
    tick(); tick();
    m_req_tready = 1'b0;
    tick();
    checks++; if (status_out !== 32'h0000_0013) begin errors++; $display("FAIL midop_status: got %h expected 00000013", status_out); end
    checks++; if (m_req_tvalid !== 1'b1 || m_req_tdata !== 64'hA000_0000_0000_0002) begin errors++; $display("FAIL midop_fwd: got %b/%h expected 1/a000000000000002", m_req_tvalid, m_req_tdata); end
    reset_n      = 1'b0;
    s_rsp_tvalid = 1'b1;
    s_rsp_tdata  = 64'h77;
    #1;
    checks++; if (s_req_tready !== 4'b0000) begin errors++; $display("FAIL midop_ready_in_reset: got %b expected 0000", s_req_tready); end
    tick();
    checks++; if (m_req_tvalid !== 1'b0 || m_req_tdata !== 64'h0) begin errors++; $display("FAIL midop_m_req: got %b/%h expected 0/0", m_req_tvalid, m_req_tdata); end
    checks++; if (m_rsp_tvalid !== 4'b0000 || m_rsp_tdata !== 64'h0 || s_rsp_tready !== 1'b0) begin errors++; $display("FAIL midop_rsp: got %b/%h/%b expected 0000/0/0", m_rsp_tvalid, m_rsp_tdata, s_rsp_tready); end
    checks++; if (status_out !== 32'h0) begin errors++; $display("FAIL midop_status_reset: got %h expected 00000000", status_out); end
    s_rsp_tvalid = 1'b0;
    reset_n      = 1'b1;
    #1;
    checks++; if (s_req_tready !== 4'b0001) begin errors++; $display("FAIL midop_regrant: got %b expected 0001", s_req_tready); end
    s_req_tvalid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fwd_stall();
    test_fifo_full();
    test_overflow();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
